// File: rtl/soc_pkg.sv
// Shared types and constants for tiny_soc: TX/RX state encodings and the boot message ROM.
package soc_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_GAP,
      TX_DONE
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned MSG_LEN   = 3;
   localparam int unsigned MSG_IDX_W = 2;

   localparam logic [7:0] MSG_ROM [MSG_LEN] = '{8'h48, 8'h49, 8'h0A};

   // Out-of-range indices read as idle-high so a bad index can never emit a start bit pattern.
   function automatic logic [7:0] msg_byte(input logic [MSG_IDX_W-1:0] idx);
      case (idx)
         2'd0:    return MSG_ROM[0];
         2'd1:    return MSG_ROM[1];
         2'd2:    return MSG_ROM[2];
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/soc_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle byte-valid strobe.
module soc_uart_rx
   import soc_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]       sync_q;
   logic             rx_s;
   rx_state_t        state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [2:0]       bit_q, bit_n;
   logic [7:0]       shift_q, shift_n;
   logic             valid_n;
   logic [7:0]       data_n;

   assign rx_s = sync_q[1];

   // rst_n is an active-high synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sync_q     <= 2'b11;
         state_q    <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
      end else begin
         sync_q     <= {sync_q[0], uart_rx};
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         bit_q      <= bit_n;
         shift_q    <= shift_n;
         byte_valid <= valid_n;
         byte_data  <= data_n;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      bit_n   = bit_q;
      shift_n = shift_q;
      valid_n = 1'b0;
      data_n  = byte_data;
      case (state_q)
         RX_IDLE: begin
            cnt_n = '0;
            bit_n = '0;
            if (!rx_s) state_n = RX_START;
         end
         RX_START: begin
            // A start that no longer reads low at mid-bit is a glitch.
            if (cnt_q == HALF_LAST) begin
               cnt_n   = '0;
               state_n = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n   = '0;
               shift_n = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) state_n = RX_STOP;
               else               bit_n   = bit_q + 3'd1;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n   = '0;
               state_n = RX_IDLE;
               if (rx_s) begin
                  valid_n = 1'b1;
                  data_n  = shift_q;
               end
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/tiny_soc.sv
// Tiny SoC: sends a fixed 3-byte UART message once per reset and drives gpio from received bytes.
module tiny_soc
   import soc_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned GAP_CYCLES   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic [3:0] gpio
);

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [MSG_IDX_W-1:0] MSG_LAST = MSG_IDX_W'(MSG_LEN - 1);

   tx_state_t            state_q, state_n;
   logic [CNT_W-1:0]     cnt_q, cnt_n;
   logic [2:0]           bit_q, bit_n;
   logic [MSG_IDX_W-1:0] msg_q, msg_n;
   logic                 tx_n;
   logic [7:0]           cur_byte;
   logic                 rx_valid;
   logic [7:0]           rx_byte;
   logic                 unused_rx_hi;

   assign unused_rx_hi = ^rx_byte[7:4];

   soc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rx    (uart_rx),
      .byte_valid (rx_valid),
      .byte_data  (rx_byte)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         msg_q   <= '0;
         uart_tx <= 1'b1;
         gpio    <= 4'h0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         bit_q   <= bit_n;
         msg_q   <= msg_n;
         uart_tx <= tx_n;
         if (rx_valid) gpio <= rx_byte[3:0];
      end
   end

   // tx_n is the line level for the next cycle, so every transition lands exactly on a bit boundary.
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      bit_n    = bit_q;
      msg_n    = msg_q;
      tx_n     = uart_tx;
      cur_byte = msg_byte(msg_q);
      case (state_q)
         TX_IDLE: begin
            state_n = TX_START;
            cnt_n   = '0;
            bit_n   = '0;
            tx_n    = 1'b0;
         end
         TX_START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n   = '0;
               bit_n   = '0;
               state_n = TX_DATA;
               tx_n    = cur_byte[0];
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         TX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n = '0;
               if (bit_q == 3'd7) begin
                  state_n = TX_STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n = bit_q + 3'd1;
                  tx_n  = cur_byte[bit_n];
               end
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         TX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_n = '0;
               tx_n  = 1'b1;
               if (msg_q == MSG_LAST) begin
                  state_n = TX_DONE;
               end else if (GAP_CYCLES == 0) begin
                  state_n = TX_START;
                  msg_n   = msg_q + MSG_IDX_W'(1);
                  tx_n    = 1'b0;
               end else begin
                  state_n = TX_GAP;
               end
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         TX_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_n   = '0;
               state_n = TX_START;
               msg_n   = msg_q + MSG_IDX_W'(1);
               tx_n    = 1'b0;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
            end
         end
         TX_DONE: tx_n = 1'b1;
         default: state_n = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_tiny_soc.sv
// Self-checking bench for tiny_soc: TX waveform model, loopback, RX vector table and random frames.
module tb_tiny_soc;

   localparam int CPB   = 16;
   localparam int GAP   = 1;
   localparam int FRAME = 10 * CPB + GAP;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       ext_rx = 1'b1;
   logic       loop   = 1'b0;
   logic       uart_rx;
   logic       uart_tx;
   logic [3:0] gpio;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] msg [3] = '{8'h48, 8'h49, 8'h0A};

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       glitch;
      logic [3:0] exp;
   } rx_vec_t;

   rx_vec_t vecs [9];

   assign uart_rx = loop ? uart_tx : ext_rx;

   tiny_soc #(.CLKS_PER_BIT(CPB), .GAP_CYCLES(GAP)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .uart_tx (uart_tx),
      .uart_rx (uart_rx),
      .gpio    (gpio)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected line level c cycles after the first post-reset edge, from the framing rules.
   function automatic logic exp_tx(input int c);
      int k;
      int off;
      logic [7:0] b;
      k   = c / FRAME;
      off = c % FRAME;
      if (k >= 3) return 1'b1;
      b = msg[k];
      if (off < CPB)     return 1'b0;
      if (off < 9 * CPB) return b[(off - CPB) / CPB];
      return 1'b1;
   endfunction

   // Call on the negedge where reset was just released; checks cycles 0..ncyc-1.
   task automatic run_tx_check(input int ncyc);
      int k;
      int off;
      logic [7:0] prev;
      logic [7:0] cur;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         check($sformatf("uart_tx c=%0d", c), 32'(uart_tx), 32'(exp_tx(c)));
         k   = c / FRAME;
         off = c % FRAME;
         if (k < 3) begin
            cur  = msg[k];
            prev = (k == 0) ? 8'h00 : msg[k - 1];
            if (off == 140) check($sformatf("loop gpio pre byte%0d", k), 32'(gpio), 32'(prev[3:0]));
            if (off == 158) check($sformatf("loop gpio post byte%0d", k), 32'(gpio), 32'(cur[3:0]));
         end
         if (c >= 600 && (c % 250) == 0) check($sformatf("loop gpio hold c=%0d", c), 32'(gpio), 32'h0A);
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop);
      ext_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         ext_rx = data[i];
         repeat (CPB) @(negedge clk);
      end
      ext_rx = stop;
      repeat (CPB) @(negedge clk);
      ext_rx = 1'b1;
   endtask

   task automatic send_glitch(input int len);
      ext_rx = 1'b0;
      repeat (len) @(negedge clk);
      ext_rx = 1'b1;
   endtask

   initial begin
      logic [3:0] model;
      logic [7:0] d;
      logic       s;
      int         r;

      vecs[0] = '{8'h35, 1'b0, 1'b0, 4'hA};
      vecs[1] = '{8'h35, 1'b1, 1'b0, 4'h5};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 4'h5};
      vecs[3] = '{8'hC7, 1'b1, 1'b0, 4'h7};
      vecs[4] = '{8'h20, 1'b0, 1'b0, 4'h7};
      vecs[5] = '{8'hFF, 1'b1, 1'b0, 4'hF};
      vecs[6] = '{8'h00, 1'b1, 1'b1, 4'hF};
      vecs[7] = '{8'h00, 1'b1, 1'b0, 4'h0};
      vecs[8] = '{8'hA9, 1'b1, 1'b0, 4'h9};

      // Reset held: line idle, gpio cleared.
      loop = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("reset uart_tx i=%0d", i), 32'(uart_tx), 32'h1);
         check($sformatf("reset gpio i=%0d", i), 32'(gpio), 32'h0);
      end

      // Full message with loopback over a 50 us run.
      rst_n = 1'b0;
      run_tx_check(5000);

      // Reset during byte 1 data bits, then the message restarts from 0x48.
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      run_tx_check(217);
      @(negedge clk);
      check("midreset gpio before", 32'(gpio), 32'h8);
      rst_n = 1'b1;
      @(negedge clk);
      check("midreset uart_tx", 32'(uart_tx), 32'h1);
      check("midreset gpio", 32'(gpio), 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      run_tx_check(600);

      // External RX vectors.
      loop   = 1'b0;
      ext_rx = 1'b1;
      repeat (40) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].glitch) send_glitch(3);
         else                send_frame(vecs[i].data, vecs[i].stop);
         repeat (20) @(negedge clk);
         check($sformatf("rx vec %0d", i), 32'(gpio), 32'(vecs[i].exp));
      end

      // Random frames, framing errors and short glitches against the gpio model.
      model = vecs[8].exp;
      for (int i = 0; i < 24; i++) begin
         r = $urandom_range(0, 3);
         if (r == 0) begin
            send_glitch($urandom_range(1, 5));
         end else begin
            d = 8'($urandom);
            s = ($urandom_range(0, 2) != 0);
            send_frame(d, s);
            if (s) model = d[3:0];
         end
         repeat ($urandom_range(16, 40)) @(negedge clk);
         check($sformatf("rx rand %0d", i), 32'(gpio), 32'(model));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tiny_soc.md
TINY_SOC -- requirements
Module: tiny_soc

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per UART bit (range 4..65535, even).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, meaning idle-high cycles inserted between transmitted frames.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high (asserted when 1) despite the name.
REQ-005 SHALL have port uart_tx, output, 1 bit: UART transmit line, 8N1, idle high.
REQ-006 SHALL have port uart_rx, input, 1 bit: UART receive line, 8N1, idle high, asynchronous to clk.
REQ-007 SHALL have port gpio, output, 4 bits: registered general-purpose output.

Function
REQ-008 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-009 SHALL hold a fixed 3-byte message ROM: 0x48, 0x49, 0x0A.
REQ-010 SHALL begin the start bit of byte 0 on the first rising edge after reset is sampled deasserted.
REQ-011 SHALL send bytes in ROM order, with exactly GAP_CYCLES idle-high cycles between a stop bit's end and the next start bit.
REQ-012 SHALL, after byte 2's stop bit, hold uart_tx high permanently until the next reset; the message is sent once per reset.
REQ-013 SHALL use TX states IDLE, START, DATA, STOP, GAP, DONE, with a bit-period counter and a 3-bit data index.
REQ-014 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-015 SHALL, in RX IDLE, detect a start when the synchronized line is 0, then check it at mid-bit (CLKS_PER_BIT/2 cycles later); if it reads 1, treat it as a glitch and return to IDLE.
REQ-016 SHALL sample each data bit and the stop bit at their mid-bit points, spaced CLKS_PER_BIT apart.
REQ-017 SHALL, when the stop bit samples 1, load gpio with received byte bits [3:0] on the cycle after the stop sample.
REQ-018 SHALL, when the stop bit samples 0 (framing error), discard the byte and leave gpio unchanged.
REQ-019 SHALL return RX to IDLE right after the stop sample, so a new start bit is accepted immediately.
REQ-020 SHALL run TX and RX independently, so simultaneous TX activity and RX reception do not interfere.
REQ-021 SHALL, with uart_rx tied to uart_tx, take gpio through 0x8, then 0x9, then 0xA, and hold 0xA.

Reset
REQ-022 SHALL, while reset is asserted, drive uart_tx=1 and gpio=0x0, place TX in IDLE at ROM index 0, place RX in IDLE, clear all counters and set synchronizer flops to 1.
REQ-023 SHALL, on reset asserted mid-frame, drive uart_tx high on the next edge, abort any partial RX byte without changing gpio except to clear it, and restart the message from byte 0 after release.

Structure
REQ-024 SHALL place the TX/RX state encodings, the message ROM constant and its length (3) in a shared package soc_pkg.
REQ-025 SHALL implement the UART receiver as one sub-module, soc_uart_rx (synchronizer, FSM, byte-valid strobe); TX and message sequencer stay in tiny_soc.

Verification
REQ-026 SHALL cover reset: hold reset 10 cycles -> uart_tx=1 and gpio=0 throughout.
REQ-027 SHALL cover TX timing with defaults (CLKS_PER_BIT=16, GAP_CYCLES=1) and reset released: uart_tx low for cycles 0-15, then 0x48 LSB first (0,0,0,1,0,0,1,0) at 16 cycles each, high for cycles 144-159, idle cycle 160, byte 1 start at cycle 161.
REQ-028 SHALL cover loopback: with uart_rx=uart_tx, gpio=0x8 about 1 cycle after byte 0's stop-bit midpoint, then 0x9, then 0xA stable to end of a 50 us run; uart_tx stays high after about 484 cycles.
REQ-029 SHALL cover framing error: drive external frame 0x35 with stop bit 0 -> gpio unchanged; then a valid 0x35 -> gpio=0x5.
REQ-030 SHALL cover glitch rejection: a 3-cycle low pulse on uart_rx -> no gpio change and RX back to IDLE.
REQ-031 SHALL cover reset mid-frame: assert reset during byte 1's DATA state -> uart_tx=1 and gpio=0 next edge; after release the full message restarts with 0x48.
